// File: rtl/memwb_pkg.sv
// Shared types and constants for the MEM/WB skid stage.
package memwb_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } skid_state_e;

    localparam int WB_MEMTOREG_BIT = 0;
    localparam int WB_REGWRITE_BIT = 1;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_CTRL_W = 2;

    typedef struct packed {
        logic [DEF_CTRL_W-1:0] wb_ctrl;
        logic [DEF_DATA_W-1:0] read_data;
        logic [DEF_DATA_W-1:0] alu_result;
        logic [DEF_ADDR_W-1:0] rd_addr;
    } memwb_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: main register M feeds the output, S absorbs
// the one extra entry accepted while ready_o is still registered high.
module pipe_skid_buf
    import memwb_pkg::*;
#(
    parameter int PAYLOAD_W = 71
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [PAYLOAD_W-1:0] data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [PAYLOAD_W-1:0] data_o
);

    skid_state_e          state_q, state_d;
    logic [PAYLOAD_W-1:0] m_q, m_d, s_q, s_d;
    logic                 valid_q, valid_d, ready_q, ready_d;
    logic                 in_fire, out_fire;

    assign in_fire  = valid_i & ready_q;
    assign out_fire = valid_q & ready_i;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (in_fire) begin
                    m_d     = data_i;
                    state_d = FULL;
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        m_d = data_i;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end else if (in_fire) begin
                        s_d     = data_i;
                        state_d = SKID;
                    end
                end
                SKID: if (out_fire) begin
                    m_d     = s_q;
                    state_d = FULL;
                end
                default: state_d = EMPTY;
            endcase
        end
        // Handshake outputs are registered from the next state.
        valid_d = (state_d != EMPTY);
        ready_d = (state_d != SKID);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= EMPTY;
            m_q     <= '0;
            s_q     <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign valid_o = valid_q;
    assign ready_o = ready_q;
    assign data_o  = m_q;

endmodule

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline register with valid/ready skid buffering, flush and zero-register
// write masking. Define MEMWB_PERF_CNT_EN to add stall/flush performance counters.
module memwb_skid_stage
    import memwb_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int CTRL_W        = 2,
    parameter int ZERO_REG_MASK = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] wb_ctrl_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] wb_ctrl_o,
    output logic [DATA_W-1:0] read_data_o,
    output logic [DATA_W-1:0] alu_result_o,
`ifdef MEMWB_PERF_CNT_EN
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o,
`endif
    output logic [ADDR_W-1:0] rd_addr_o
);

    localparam int PAYLOAD_W = CTRL_W + 2*DATA_W + ADDR_W;

    logic [CTRL_W-1:0]    ctrl_in;
    logic [PAYLOAD_W-1:0] pl_in, pl_out;

    // Masking at the input covers both M and S loads.
    always_comb begin
        ctrl_in = wb_ctrl_i;
        if ((ZERO_REG_MASK != 0) && (rd_addr_i == '0))
            ctrl_in[WB_REGWRITE_BIT] = 1'b0;
    end

    assign pl_in = {ctrl_in, read_data_i, alu_result_i, rd_addr_i};

    pipe_skid_buf #(.PAYLOAD_W(PAYLOAD_W)) u_buf (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (pl_in),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (pl_out)
    );

    assign {wb_ctrl_o, read_data_o, alu_result_o, rd_addr_o} = pl_out;

`ifdef MEMWB_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Saturating counters; valid_o high is equivalent to state != EMPTY.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (valid_o && !ready_i && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_i && valid_o && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Bench for memwb_skid_stage: queue-based occupancy model checked every cycle,
// plus directed literal checks for streaming, skid, mask, flush and reset.
module tb_memwb_skid_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i, valid_i, ready_i;
    logic        ready_o, valid_o;
    logic [1:0]  wb_ctrl_i, wb_ctrl_o;
    logic [31:0] read_data_i, read_data_o, alu_result_i, alu_result_o;
    logic [4:0]  rd_addr_i, rd_addr_o;
`ifdef MEMWB_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    memwb_skid_stage dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .wb_ctrl_i    (wb_ctrl_i),
        .read_data_i  (read_data_i),
        .alu_result_i (alu_result_i),
        .rd_addr_i    (rd_addr_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .wb_ctrl_o    (wb_ctrl_o),
        .read_data_o  (read_data_o),
        .alu_result_o (alu_result_o),
`ifdef MEMWB_PERF_CNT_EN
        .stall_cnt_o  (stall_cnt),
        .flush_cnt_o  (flush_cnt),
`endif
        .rd_addr_o    (rd_addr_o)
    );

    typedef struct {
        logic [1:0]  c;
        logic [31:0] rdat;
        logic [31:0] alu;
        logic [4:0]  rd;
    } ent_t;

    ent_t q[$];    // entries held by the stage, oldest first
    ent_t dlv[$];  // entries handed downstream
    int   n_pass = 0, n_tot = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: occupancy <=2, ready when fewer than 2 held, flush empties everything.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            bit   inf, outf;
            ent_t e;
            inf  = valid_i && (q.size() < 2);
            outf = (q.size() > 0) && ready_i;
            if (outf) dlv.push_back(q[0]);
            if (flush_i) begin
                q.delete();
            end else begin
                if (outf) void'(q.pop_front());
                if (inf) begin
                    e.c = wb_ctrl_i; e.rdat = read_data_i; e.alu = alu_result_i; e.rd = rd_addr_i;
                    if (e.rd == 5'd0) e.c[1] = 1'b0;
                    q.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("valid_o", {63'd0, valid_o}, {63'd0, q.size() > 0});
            chk("ready_o", {63'd0, ready_o}, {63'd0, q.size() < 2});
            if (q.size() > 0) begin
                chk("wb_ctrl_o",    64'(wb_ctrl_o),    64'(q[0].c));
                chk("read_data_o",  64'(read_data_o),  64'(q[0].rdat));
                chk("alu_result_o", 64'(alu_result_o), 64'(q[0].alu));
                chk("rd_addr_o",    64'(rd_addr_o),    64'(q[0].rd));
            end
        end
    end

    task automatic step(input logic v, input logic [1:0] c, input logic [4:0] rd,
                        input logic [31:0] alu, input logic rdy, input logic fl);
        valid_i = v; wb_ctrl_i = c; rd_addr_i = rd; alu_result_i = alu;
        read_data_i = alu ^ 32'hA5A5_0000; ready_i = rdy; flush_i = fl;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 0; valid_i = 0; ready_i = 0;
        wb_ctrl_i = 0; read_data_i = 0; alu_result_i = 0; rd_addr_i = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // Reset state
        chk("rst valid_o", 64'(valid_o), 64'd0);
        chk("rst ready_o", 64'(ready_o), 64'd1);
        chk("rst payload", 64'({wb_ctrl_o, rd_addr_o}), 64'd0);
        chk("rst alu/rdata", {alu_result_o, read_data_o}, 64'd0);

        // Streaming with ready_i=1
        dlv.delete();
        for (int i = 1; i <= 4; i++) begin
            step(1, 2'b01, 5'(i), 32'(i * 16), 1, 0);
            if (i == 1) begin
                chk("stream first valid", 64'(valid_o), 64'd1);
                chk("stream first rd", 64'(rd_addr_o), 64'd1);
            end
        end
        step(0, 0, 0, 0, 1, 0);
        chk("stream count", 64'(dlv.size()), 64'd4);
        for (int i = 0; i < 4 && i < dlv.size(); i++) begin
            chk("stream rd", 64'(dlv[i].rd), 64'(i + 1));
            chk("stream alu", 64'(dlv[i].alu), 64'((i + 1) * 16));
        end

        // Skid: A then B under backpressure
        dlv.delete();
        step(1, 2'b11, 5'd3, 32'hAA, 0, 0);
        chk("skid A ready", 64'(ready_o), 64'd1);
        step(1, 2'b11, 5'd4, 32'hBB, 0, 0);
        chk("skid ready low", 64'(ready_o), 64'd0);
        chk("skid holds A", 64'(rd_addr_o), 64'd3);
        step(0, 0, 0, 0, 1, 0);
        chk("skid ready back", 64'(ready_o), 64'd1);
        chk("skid B next", 64'(rd_addr_o), 64'd4);
        step(0, 0, 0, 0, 1, 0);
        chk("skid drained", 64'(valid_o), 64'd0);
        chk("skid order", {dlv.size() > 1 ? 32'(dlv[0].rd) : 32'hFFFF, dlv.size() > 1 ? 32'(dlv[1].rd) : 32'hFFFF},
            {32'd3, 32'd4});

        // Zero-register mask
        step(1, 2'b10, 5'd0, 32'h55, 1, 0);
        chk("mask rd0", 64'(wb_ctrl_o), 64'd0);
        step(1, 2'b10, 5'd7, 32'h66, 1, 0);
        chk("mask rd7", 64'(wb_ctrl_o), 64'd2);
        step(0, 0, 0, 0, 1, 0);

        // Flush while SKID with a coincident valid input
        dlv.delete();
        step(1, 2'b01, 5'd5, 32'h50, 0, 0);
        step(1, 2'b01, 5'd6, 32'h60, 0, 0);
        step(1, 2'b01, 5'd9, 32'h99, 0, 1);
        chk("flush valid", 64'(valid_o), 64'd0);
        chk("flush ready", 64'(ready_o), 64'd1);
`ifdef MEMWB_PERF_CNT_EN
        chk("flush_cnt", 64'(flush_cnt), 64'd1);
`endif
        step(0, 0, 0, 0, 1, 0);
        chk("flush lost", 64'(valid_o), 64'd0);
        chk("flush delivered", 64'(dlv.size()), 64'd0);

        // Asynchronous reset mid-stream
        step(1, 2'b11, 5'd10, 32'hA0, 0, 0);
        step(1, 2'b11, 5'd11, 32'hB0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst valid", 64'(valid_o), 64'd0);
        chk("arst ready", 64'(ready_o), 64'd1);
        chk("arst rd", 64'(rd_addr_o), 64'd0);
`ifdef MEMWB_PERF_CNT_EN
        chk("arst stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst valid", 64'(valid_o), 64'd0);
        step(1, 2'b10, 5'd12, 32'h120, 1, 0);
        chk("post-rst rd", 64'(rd_addr_o), 64'd12);
        chk("post-rst alu", 64'(alu_result_o), 64'h120);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
